// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, oversampling
// constants and the parity mode encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // data_xor is the XOR of all data bits; the result is 1 when the received
  // parity bit disagrees with the configured mode.
  function automatic logic parity_mismatch(input logic data_xor,
                                           input logic par_bit,
                                           input int   mode);
    logic odd_total;
    odd_total = data_xor ^ par_bit;
    if (mode == PAR_EVEN) begin
      return odd_total;
    end else if (mode == PAR_ODD) begin
      return ~odd_total;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high serial input.
// Both flops reset to 1 so a line that idles high never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receive engine: qualifies the start bit, samples each
// bit mid-cell and presents the word with a one-cycle done pulse and flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = PAR_NONE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int S_W = (SB_TICK > OVERSAMPLE) ? 5 : 4;
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0] S_MID  = S_W'(MID_SAMPLE);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

  logic rx_s;

  rx_state_t       state_q,      state_d;
  logic [S_W-1:0]  s_cnt_q,      s_cnt_d;
  logic [N_W-1:0]  n_cnt_q,      n_cnt_d;
  logic [DBIT-1:0] b_q,          b_d;
  logic            par_bit_q,    par_bit_d;
  logic            break_hold_q, break_hold_d;
  logic [DBIT-1:0] dout_q,       dout_d;
  logic            done_q,       done_d;
  logic            ferr_q,       ferr_d;
  logic            perr_q,       perr_d;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      s_cnt_q      <= '0;
      n_cnt_q      <= '0;
      b_q          <= '0;
      par_bit_q    <= 1'b0;
      break_hold_q <= 1'b0;
      dout_q       <= '0;
      done_q       <= 1'b0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_cnt_q      <= s_cnt_d;
      n_cnt_q      <= n_cnt_d;
      b_q          <= b_d;
      par_bit_q    <= par_bit_d;
      break_hold_q <= break_hold_d;
      dout_q       <= dout_d;
      done_q       <= done_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
    end
  end

  // NOTE: every signal written below gets a hold/default value first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    n_cnt_d      = n_cnt_q;
    b_d          = b_q;
    par_bit_d    = par_bit_q;
    break_hold_d = break_hold_q;
    dout_d       = dout_q;
    done_d       = 1'b0;
    ferr_d       = ferr_q;
    perr_d       = perr_q;

    // A frame that ended on a low line (break) must see the line high again
    // before the next falling edge may count as a start bit.
    if (rx_s) begin
      break_hold_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s && !break_hold_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_cnt_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == S_LAST) begin
            b_d     = {rx_s, b_q[DBIT-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == N_LAST) begin
              if (PARITY != PAR_NONE) begin
                state_d = PAR;
              end else begin
                state_d = STOP;
              end
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      PAR: begin
        if (s_tick) begin
          if (s_cnt_q == S_LAST) begin
            par_bit_d = rx_s;
            state_d   = STOP;
            s_cnt_d   = '0;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == S_STOP) begin
            state_d      = IDLE;
            dout_d       = b_q;
            ferr_d       = ~rx_s;
            perr_d       = parity_mismatch(^b_q, par_bit_q, PARITY);
            done_d       = 1'b1;
            break_hold_d = ~rx_s;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_dout      = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign parity_err   = perr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench: an 8N1 receiver plus even/odd parity receivers sharing
// one line, driven by a bit-level transmitter and checked against a frame model.
module tb_uart_receiver;

  localparam int TICK_DIV = 5;

  logic clk = 1'b0;
  logic reset;
  logic s_tick;
  logic rx0;
  logic rx_p;

  logic [7:0] dout0, dout_e, dout_o;
  logic       done0, done_e, done_o;
  logic       ferr0, ferr_e, ferr_o;
  logic       perr0, perr_e, perr_o;

  int ticks_done = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] dout;
    logic       ferr;
    logic       perr;
    int         tick;
  } obs_t;

  typedef struct {
    logic [7:0] dout;
    logic       ferr;
    logic       perr;
    int         t0;
    int         lat;
  } exp_t;

  typedef struct {
    int         line;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic       exp_ferr;
    logic       exp_perr_e;
    logic       exp_perr_o;
  } vec_t;

  obs_t got0[$], got_e[$], got_o[$];
  exp_t exp0[$], exp_e[$], exp_o[$];
  logic prev0 = 1'b0, prev_e = 1'b0, prev_o = 1'b0;

  always #5 clk = ~clk;

  uart_receiver #(.DBIT(8), .SB_TICK(16), .PARITY(0)) dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx0),
    .rx_dout(dout0), .rx_done_tick(done0), .frame_err(ferr0), .parity_err(perr0)
  );

  uart_receiver #(.DBIT(8), .SB_TICK(16), .PARITY(1)) dut_e (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_p),
    .rx_dout(dout_e), .rx_done_tick(done_e), .frame_err(ferr_e), .parity_err(perr_e)
  );

  uart_receiver #(.DBIT(8), .SB_TICK(16), .PARITY(2)) dut_o (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_p),
    .rx_dout(dout_o), .rx_done_tick(done_o), .frame_err(ferr_o), .parity_err(perr_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One s_tick every TICK_DIV clocks; ticks_done counts ticks already consumed.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
      ticks_done++;
    end
  end

  always @(negedge clk) begin
    if (done0) begin
      check("8n1 pulse spacing", 32'(prev0), 32'd0);
      got0.push_back('{dout: dout0, ferr: ferr0, perr: perr0, tick: ticks_done});
    end
    if (done_e) begin
      check("even pulse spacing", 32'(prev_e), 32'd0);
      got_e.push_back('{dout: dout_e, ferr: ferr_e, perr: perr_e, tick: ticks_done});
    end
    if (done_o) begin
      check("odd pulse spacing", 32'(prev_o), 32'd0);
      got_o.push_back('{dout: dout_o, ferr: ferr_o, perr: perr_o, tick: ticks_done});
    end
    prev0  <= done0;
    prev_e <= done_e;
    prev_o <= done_o;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    int target;
    target = ticks_done + n;
    wait (ticks_done >= target);
  endtask

  task automatic set_rx(input int line, input logic v);
    if (line == 0) rx0 = v;
    else rx_p = v;
  endtask

  // Starts immediately after a consumed tick; each bit cell is 16 ticks.
  task automatic send_frame(input int line, input logic [7:0] data, input logic pbit,
                            input logic stop, output int t0);
    t0 = ticks_done;
    set_rx(line, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      set_rx(line, data[i]);
      wait_ticks(16);
    end
    if (line != 0) begin
      set_rx(line, pbit);
      wait_ticks(16);
    end
    set_rx(line, stop);
    wait_ticks(16);
    set_rx(line, 1'b1);
  endtask

  // Reference: word is the data sent, frame error mirrors the stop bit,
  // parity error is the oddness/evenness of the total count of ones.
  function automatic exp_t model(input logic [7:0] data, input logic pbit,
                                 input logic stop, input int mode, input int t0);
    exp_t e;
    int   ones;
    ones   = $countones(data) + int'(pbit);
    e.dout = data;
    e.ferr = !stop;
    if (mode == 0)      e.perr = 1'b0;
    else if (mode == 1) e.perr = (ones % 2) != 0;
    else                e.perr = (ones % 2) == 0;
    e.t0  = t0;
    e.lat = 8 + 16 * 8 + ((mode != 0) ? 16 : 0) + 16;
    return e;
  endfunction

  function automatic void push_exp(input int k, input exp_t e);
    if (k == 0)      exp0.push_back(e);
    else if (k == 1) exp_e.push_back(e);
    else             exp_o.push_back(e);
  endfunction

  function automatic int exp_size(input int k);
    if (k == 0) return exp0.size();
    if (k == 1) return exp_e.size();
    return exp_o.size();
  endfunction

  function automatic int got_size(input int k);
    if (k == 0) return got0.size();
    if (k == 1) return got_e.size();
    return got_o.size();
  endfunction

  function automatic exp_t exp_pop(input int k);
    if (k == 0) return exp0.pop_front();
    if (k == 1) return exp_e.pop_front();
    return exp_o.pop_front();
  endfunction

  function automatic obs_t got_pop(input int k);
    if (k == 0) return got0.pop_front();
    if (k == 1) return got_e.pop_front();
    return got_o.pop_front();
  endfunction

  task automatic drain(input int k);
    exp_t  e;
    obs_t  o;
    string nm;
    nm = (k == 0) ? "8n1" : ((k == 1) ? "even" : "odd");
    while (exp_size(k) > 0) begin
      e = exp_pop(k);
      if (got_size(k) == 0) begin
        check({nm, " pulse present"}, 32'(got_size(k)), 32'd1);
      end else begin
        o = got_pop(k);
        check({nm, " rx_dout"},    32'(o.dout), 32'(e.dout));
        check({nm, " frame_err"},  32'(o.ferr), 32'(e.ferr));
        check({nm, " parity_err"}, 32'(o.perr), 32'(e.perr));
        check({nm, " latency"},    o.tick - e.t0, e.lat);
      end
    end
    check({nm, " no extra pulses"}, 32'(got_size(k)), 32'd0);
  endtask

  initial begin
    vec_t       vecs[8];
    exp_t       e;
    int         t0;
    logic [7:0] d96;
    logic [7:0] rdata;
    logic       rpbit, rstop;
    int         gap;

    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    reset = 1'b0;
    rx0   = 1'b1;
    rx_p  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_dout",       32'(dout0), 32'd0);
    check("reset rx_done_tick",  32'(done0), 32'd0);
    check("reset frame_err",     32'(ferr0), 32'd0);
    check("reset parity_err",    32'(perr_e), 32'd0);
    reset = 1'b1;
    wait_ticks(2);

    // Directed vectors with explicit expected results.
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].line, vecs[i].data, vecs[i].pbit, vecs[i].stop, t0);
      e.dout = vecs[i].data;
      e.ferr = vecs[i].exp_ferr;
      e.t0   = t0;
      if (vecs[i].line == 0) begin
        e.perr = 1'b0;
        e.lat  = 152;
        push_exp(0, e);
      end else begin
        e.lat  = 168;
        e.perr = vecs[i].exp_perr_e;
        push_exp(1, e);
        e.perr = vecs[i].exp_perr_o;
        push_exp(2, e);
      end
      wait_ticks(2);
    end
    drain(0);
    drain(1);
    drain(2);

    // Start glitch of 3 ticks: rejected, then a real frame right after tick 9.
    set_rx(0, 1'b0);
    wait_ticks(3);
    set_rx(0, 1'b1);
    wait_ticks(6);
    send_frame(0, 8'h5A, 1'b0, 1'b1, t0);
    push_exp(0, model(8'h5A, 1'b0, 1'b1, 0, t0));
    wait_ticks(2);
    drain(0);

    // Back-to-back frames, zero idle between stop and next start.
    send_frame(0, 8'h00, 1'b0, 1'b1, t0);
    push_exp(0, model(8'h00, 1'b0, 1'b1, 0, t0));
    send_frame(0, 8'hFF, 1'b0, 1'b1, t0);
    push_exp(0, model(8'hFF, 1'b0, 1'b1, 0, t0));
    send_frame(0, 8'h81, 1'b0, 1'b1, t0);
    push_exp(0, model(8'h81, 1'b0, 1'b1, 0, t0));
    wait_ticks(2);
    drain(0);

    // Reset in the middle of data bit 4 of 0x96 aborts the frame at once.
    d96 = 8'h96;
    set_rx(0, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      set_rx(0, d96[i]);
      wait_ticks(16);
    end
    set_rx(0, d96[4]);
    wait_ticks(8);
    reset = 1'b0;
    #1;
    check("mid-frame reset rx_dout",      32'(dout0), 32'd0);
    check("mid-frame reset rx_done_tick", 32'(done0), 32'd0);
    check("mid-frame reset frame_err",    32'(ferr0), 32'd0);
    set_rx(0, 1'b1);
    #20;
    reset = 1'b1;
    wait_ticks(20);
    drain(0);
    send_frame(0, 8'h12, 1'b0, 1'b1, t0);
    push_exp(0, model(8'h12, 1'b0, 1'b1, 0, t0));
    wait_ticks(2);
    drain(0);

    // Randomised frames on both lines against the model.
    for (int i = 0; i < 12; i++) begin
      rdata = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      gap   = $urandom_range(0, 2);
      if (!rstop && gap == 0) gap = 1;
      send_frame(0, rdata, 1'b0, rstop, t0);
      push_exp(0, model(rdata, 1'b0, rstop, 0, t0));
      wait_ticks(gap);
    end
    wait_ticks(2);
    drain(0);

    for (int i = 0; i < 12; i++) begin
      rdata = 8'($urandom);
      rpbit = 1'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      gap   = $urandom_range(0, 2);
      if (!rstop && gap == 0) gap = 1;
      send_frame(1, rdata, rpbit, rstop, t0);
      push_exp(1, model(rdata, rpbit, rstop, 1, t0));
      push_exp(2, model(rdata, rpbit, rstop, 2, t0));
      wait_ticks(gap);
    end
    wait_ticks(2);
    drain(1);
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive engine, 16x oversampled. Consumes the one-cycle `done` tick of `baud_rate_generator`, configured for 16 ticks per bit, as its sample enable. It synchronises the asynchronous `rx` line, detects and qualifies the start bit, and samples each bit at mid-period. It presents the assembled word with a one-cycle valid pulse and error flags to the downstream FIFO or host logic.

## Interface
- `DBIT`, 8: data bits per frame, 5–9.
- `SB_TICK`, 16: ticks spent in stop state; 16 = 1 stop bit, 32 = 2 stop bits.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `clk` input 1: system clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-low. Clears all state and outputs.
- `s_tick` input 1: 16x-baud sample enable. One `clk` wide, from `baud_rate_generator` `done`.
- `rx` input 1: asynchronous serial line. Idles high.
- `rx_dout` output DBIT: last received word, LSB = first data bit. Held until the next completed frame.
- `rx_done_tick` output 1: one-cycle pulse; `rx_dout` and the flags are valid in the same cycle.
- `frame_err` output 1: sampled stop bit was 0. Updated with `rx_done_tick`.
- `parity_err` output 1: parity mismatch. Constant 0 when `PARITY`=0. Updated with `rx_done_tick`.

## Operation
- `rx` passes through a 2-flop synchroniser to `rx_s`. The synchroniser flops reset to 1.
- Counters:
  - `s_cnt`: 4 bits, or 5 bits if `SB_TICK`>16. Advances only on `s_tick`.
  - `n_cnt`: bit index, ceil(log2 DBIT) bits.
  - Shift register `b`, DBIT bits.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - On `rx_s`=0, go to START and set `s_cnt`=0.
  - `s_tick` is ignored in IDLE.
- START:
  - On `s_tick` with `s_cnt`=7: if `rx_s`=0, go to DATA with `s_cnt`=0 and `n_cnt`=0.
  - If `rx_s`=1 at that point, the start is false: go to IDLE. No pulse, no flag change.
- DATA:
  - On `s_tick` with `s_cnt`=15, shift right: `b` = {`rx_s`, `b`[DBIT-1:1]}. Set `s_cnt`=0.
  - If `n_cnt`=DBIT-1, go to PAR (`PARITY`≠0) or STOP. Otherwise increment `n_cnt`.
- PAR: on `s_tick` with `s_cnt`=15, latch the parity bit and go to STOP with `s_cnt`=0.
- STOP: on `s_tick` with `s_cnt`=SB_TICK-1, go to IDLE. On that same clock edge:
  - `rx_dout` ← final `b`.
  - `frame_err` ← ~`rx_s`.
  - `parity_err` ← (^`b` ^ parity bit) for even, or its complement for odd.
  - `rx_done_tick` ← 1, for the next cycle only.
- A break condition (`rx` held low) yields a frame with `frame_err`=1. The FSM then re-enters START only after `rx_s` returns to 1 and then falls again.
- In every state other than IDLE, `s_cnt` increments on `s_tick` when not at its terminal value. With no `s_tick`, all state holds.

## Timing
- Reset values:
  - FSM = IDLE.
  - All counters and `b` = 0.
  - `rx_dout` = 0, `rx_done_tick` = 0, `frame_err` = 0, `parity_err` = 0.
- Latency from `rx` falling to `rx_done_tick`:
  - 2 `clk` for the synchroniser, plus 8 + 16·DBIT + 16·(PARITY≠0) + SB_TICK `s_tick` periods, plus 1 `clk`.
  - 8N1 example: 152 ticks.
- Sample points are at 7.5 ticks into each bit cell. This tolerates up to ±3% baud mismatch.
- `rx_done_tick` is never asserted on consecutive cycles. The minimum spacing is one full frame.
- Reset asserted mid-frame aborts immediately: no pulse is produced, and `rx_dout` clears to 0.
- A `rx` falling edge in the same cycle the FSM enters IDLE is detected on the next cycle with no tick lost. Back-to-back frames with zero idle are supported.

## Structure
- Package `uart_pkg`:
  - FSM state encoding: localparams IDLE=0, START=1, DATA=2, PAR=3, STOP=4.
  - Oversampling constant `OVERSAMPLE`=16 and mid-sample constant 7.
  - Parity encodings PAR_NONE, PAR_EVEN, PAR_ODD.
- Sub-module `uart_rx_sync`: 2-flop synchroniser with reset-to-1. Reused by the later CTS input.
- The baud tick is generated externally. Top-level integration sets `FINAL_VALUE` = f_clk/(16·baud) − 1, e.g. 650 for 100 MHz at 9600.

## Test plan
- 8N1, tick every 651 clocks, send 0xA5 → one `rx_done_tick`, `rx_dout`=0xA5, both flags 0, 152 ticks after the falling edge.
- Glitch: `rx` low for 3 ticks, then high → no `rx_done_tick`; FSM back in IDLE by tick 8.
- Stop bit forced 0 on 0x3C → `rx_dout`=0x3C, `frame_err`=1. The next valid 0x55 clears `frame_err` to 0.
- `PARITY`=1, send 0x07 with parity 1 → `parity_err`=0. Same data with parity 0 → `parity_err`=1. With `PARITY`=2 the results invert.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap → three pulses, words in order.
- `reset` low at bit 4 of 0x96 → outputs are 0 immediately and no pulse occurs. The following 0x12 is received correctly.
